// File: rtl/discharge_pulse_ctrl_if.sv
// Handshake/data bundle between the SPI command block, the gap ADC and the
// discharge pulse sequencer.
interface discharge_pulse_ctrl_if;
  logic        machine_start;
  logic        machine_stop;
  logic [15:0] ton_data;
  logic [15:0] toff_data;
  logic [15:0] gap_volt;
  logic        mosfet_on;
  logic        running;
  logic [2:0]  state_o;
  logic [15:0] pulse_cnt;
  logic [15:0] short_cnt;
  logic [15:0] open_cnt;

  modport master (
    output machine_start, machine_stop, ton_data, toff_data, gap_volt,
    input  mosfet_on, running, state_o, pulse_cnt, short_cnt, open_cnt
  );

  modport slave (
    input  machine_start, machine_stop, ton_data, toff_data, gap_volt,
    output mosfet_on, running, state_o, pulse_cnt, short_cnt, open_cnt
  );
endinterface

// File: rtl/discharge_pulse_ctrl.sv
// EDM discharge pulse sequencer: energises the gap, waits for filtered breakdown,
// times Ton/Toff in prescaled units and tallies normal, short and open pulses.
module discharge_pulse_ctrl #(
  parameter int unsigned TICK_DIV     = 100,
  parameter logic [15:0] BD_MV        = 16'd15000,
  parameter logic [15:0] SHORT_MV     = 16'd3000,
  parameter int unsigned FILT         = 3,
  parameter logic [15:0] OPEN_TIMEOUT = 16'd200
) (
  input  logic                         clk,
  input  logic                         rst_n,
  discharge_pulse_ctrl_if.slave        bus
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FLT_W = (FILT > 1) ? $clog2(FILT + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_BD   = 3'd2,
    S_DISCHARGE = 3'd3,
    S_TOFF      = 3'd4
  } state_t;

  // A programmed length of 0 units behaves as 1 unit.
  function automatic logic [15:0] units_last(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic               mosfet_q, mosfet_d;
  logic               running_q, running_d;
  logic [15:0]        ton_q, ton_d;
  logic [15:0]        toff_q, toff_d;
  logic [15:0]        gap_q;
  logic [FLT_W-1:0]   bd_cnt_q, bd_cnt_d;
  logic [FLT_W-1:0]   sc_cnt_q, sc_cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [15:0]        unit_q, unit_d;
  logic [15:0]        pulse_q, pulse_d;
  logic [15:0]        short_q, short_d;
  logic [15:0]        open_q, open_d;

  logic gap_bd, gap_sc, bd_ok, sc_ok, tick_last;

  // The decision uses the stored run length plus the current sample, so the
  // FILT-th consecutive low sample is acted on in the same cycle it is seen.
  always_comb begin
    gap_bd    = (gap_q < BD_MV);
    gap_sc    = (gap_q < SHORT_MV);
    bd_ok     = gap_bd && (bd_cnt_q >= FLT_LAST);
    sc_ok     = gap_sc && (sc_cnt_q >= FLT_LAST);
    tick_last = (pre_q == PRE_LAST);
  end

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    short_d = short_q;
    open_d  = open_q;
    ton_d   = ton_q;
    toff_d  = toff_q;

    if (bus.machine_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.machine_start) begin
            state_d = S_LOAD;
            pulse_d = 16'd0;
            short_d = 16'd0;
            open_d  = 16'd0;
          end
        end
        S_LOAD: begin
          ton_d   = bus.ton_data;
          toff_d  = bus.toff_data;
          state_d = S_WAIT_BD;
        end
        S_WAIT_BD: begin
          if (sc_ok) begin
            state_d = S_TOFF;
            short_d = sat_inc(short_q);
          end else if (bd_ok) begin
            state_d = S_DISCHARGE;
          end else if (tick_last && (unit_q == units_last(OPEN_TIMEOUT))) begin
            state_d = S_TOFF;
            open_d  = sat_inc(open_q);
          end
        end
        S_DISCHARGE: begin
          if (tick_last && (unit_q == units_last(ton_q))) begin
            state_d = S_TOFF;
            pulse_d = sat_inc(pulse_q);
          end
        end
        S_TOFF: begin
          if (tick_last && (unit_q == units_last(toff_q))) begin
            state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Timer restarts on every state change; filters restart on WAIT_BD entry.
  always_comb begin
    pre_d  = pre_q;
    unit_d = unit_q;
    if (state_d != state_q) begin
      pre_d  = '0;
      unit_d = 16'd0;
    end else if (state_q != S_IDLE) begin
      pre_d  = tick_last ? '0 : pre_q + 1'b1;
      unit_d = tick_last ? unit_q + 16'd1 : unit_q;
    end

    if ((state_d == S_WAIT_BD) && (state_q != S_WAIT_BD)) begin
      bd_cnt_d = '0;
      sc_cnt_d = '0;
    end else begin
      bd_cnt_d = !gap_bd ? '0 : (bd_cnt_q >= FLT_LAST) ? bd_cnt_q : bd_cnt_q + 1'b1;
      sc_cnt_d = !gap_sc ? '0 : (sc_cnt_q >= FLT_LAST) ? sc_cnt_q : sc_cnt_q + 1'b1;
    end

    mosfet_d  = (state_d == S_WAIT_BD) || (state_d == S_DISCHARGE);
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mosfet_q  <= 1'b0;
      running_q <= 1'b0;
      ton_q     <= 16'd0;
      toff_q    <= 16'd0;
      gap_q     <= 16'hFFFF;
      bd_cnt_q  <= '0;
      sc_cnt_q  <= '0;
      pre_q     <= '0;
      unit_q    <= 16'd0;
      pulse_q   <= 16'd0;
      short_q   <= 16'd0;
      open_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      mosfet_q  <= mosfet_d;
      running_q <= running_d;
      ton_q     <= ton_d;
      toff_q    <= toff_d;
      gap_q     <= bus.gap_volt;
      bd_cnt_q  <= bd_cnt_d;
      sc_cnt_q  <= sc_cnt_d;
      pre_q     <= pre_d;
      unit_q    <= unit_d;
      pulse_q   <= pulse_d;
      short_q   <= short_d;
      open_q    <= open_d;
    end
  end

  assign bus.mosfet_on = mosfet_q;
  assign bus.running   = running_q;
  assign bus.state_o   = state_q;
  assign bus.pulse_cnt = pulse_q;
  assign bus.short_cnt = short_q;
  assign bus.open_cnt  = open_q;

endmodule

// File: tb/tb_discharge_pulse_ctrl.sv
// Directed bench for discharge_pulse_ctrl with TICK_DIV=4, FILT=3, OPEN_TIMEOUT=10.
module tb_discharge_pulse_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  discharge_pulse_ctrl_if bus();

  discharge_pulse_ctrl #(
    .TICK_DIV(4),
    .BD_MV(16'd15000),
    .SHORT_MV(16'd3000),
    .FILT(3),
    .OPEN_TIMEOUT(16'd10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] ton;
    logic [15:0] toff;
    logic [15:0] gap;
    int          cyc;
    logic [2:0]  st;
    logic        mos;
    logic        run;
    logic [15:0] pc;
    logic [15:0] sc;
    logic [15:0] oc;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int failures = 0;

  function automatic void add(int s, int p, int ton, int toff, int gap, int cyc,
                              int st, int mos, int run, int pc, int sc, int oc);
    vec_t v;
    v.start = 1'(s);     v.stop = 1'(p);
    v.ton   = 16'(ton);  v.toff = 16'(toff); v.gap = 16'(gap);
    v.cyc   = cyc;
    v.st    = 3'(st);    v.mos  = 1'(mos);   v.run = 1'(run);
    v.pc    = 16'(pc);   v.sc   = 16'(sc);   v.oc  = 16'(oc);
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " state"},  int'(bus.state_o),   int'(v.st));
    chk({tag, " mosfet"}, int'(bus.mosfet_on), int'(v.mos));
    chk({tag, " run"},    int'(bus.running),   int'(v.run));
    chk({tag, " pulse"},  int'(bus.pulse_cnt), int'(v.pc));
    chk({tag, " short"},  int'(bus.short_cnt), int'(v.sc));
    chk({tag, " open"},   int'(bus.open_cnt),  int'(v.oc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    vec_t z;

    // start stop ton toff gap cyc | state mos run pulse short open
    // Normal pulse: breakdown accepted 4 clk after the drop, 20 clk on, 32 clk off
    add(1,0,5,8,20000, 1, 1,0,1, 0,0,0);
    add(0,0,5,8,20000, 1, 2,1,1, 0,0,0);
    add(0,0,5,8,20000, 6, 2,1,1, 0,0,0);
    add(0,0,5,8,10000, 3, 2,1,1, 0,0,0);
    add(0,0,5,8,10000, 1, 3,1,1, 0,0,0);
    add(0,0,5,8,10000,19, 3,1,1, 0,0,0);
    add(0,0,5,8,10000, 1, 4,0,1, 1,0,0);
    add(0,0,5,8,20000,31, 4,0,1, 1,0,0);
    add(0,0,5,8,20000, 1, 1,0,1, 1,0,0);
    add(0,0,5,8,20000, 1, 2,1,1, 1,0,0);
    add(0,1,5,8,20000, 1, 0,0,0, 1,0,0);
    // Short (both filters true together, short wins)
    add(1,0,5,8,20000, 1, 1,0,1, 0,0,0);
    add(0,0,5,8,20000, 1, 2,1,1, 0,0,0);
    add(0,0,5,8, 1000, 3, 2,1,1, 0,0,0);
    add(0,0,5,8, 1000, 1, 4,0,1, 0,1,0);
    // Open timeout: 40 clk in WAIT_BD
    add(0,0,5,8,20000,31, 4,0,1, 0,1,0);
    add(0,0,5,8,20000, 1, 1,0,1, 0,1,0);
    add(0,0,5,8,20000, 1, 2,1,1, 0,1,0);
    add(0,0,5,8,20000,39, 2,1,1, 0,1,0);
    add(0,0,5,8,20000, 1, 4,0,1, 0,1,1);
    add(0,0,5,8,20000,16, 4,0,1, 0,1,1);
    // Glitch of 2 samples must not be accepted and must reset the filter
    add(0,0,5,8,20000,15, 4,0,1, 0,1,1);
    add(0,0,5,8,20000, 1, 1,0,1, 0,1,1);
    add(0,0,5,8,20000, 1, 2,1,1, 0,1,1);
    add(0,0,5,8,10000, 2, 2,1,1, 0,1,1);
    add(0,0,5,8,20000, 3, 2,1,1, 0,1,1);
    add(0,0,5,8,10000, 3, 2,1,1, 0,1,1);
    add(0,0,5,8,10000, 1, 3,1,1, 0,1,1);
    // Stop mid-DISCHARGE, then start+stop together in IDLE
    add(0,0,5,8,10000, 5, 3,1,1, 0,1,1);
    add(0,1,5,8,10000, 1, 0,0,0, 0,1,1);
    add(1,1,5,8,10000, 1, 0,0,0, 0,1,1);
    // Zero ton/toff act as 1 unit; ton change applies only to the next pulse
    add(1,0,0,0,10000, 1, 1,0,1, 0,0,0);
    add(0,0,0,0,10000, 1, 2,1,1, 0,0,0);
    add(0,0,0,0,10000, 2, 2,1,1, 0,0,0);
    add(0,0,0,0,10000, 1, 3,1,1, 0,0,0);
    add(0,0,3,0,10000, 3, 3,1,1, 0,0,0);
    add(0,0,3,0,10000, 1, 4,0,1, 1,0,0);
    add(0,0,3,0,10000, 3, 4,0,1, 1,0,0);
    add(0,0,3,0,10000, 1, 1,0,1, 1,0,0);
    add(0,0,3,0,10000, 1, 2,1,1, 1,0,0);
    add(0,0,3,0,10000, 2, 2,1,1, 1,0,0);
    add(0,0,3,0,10000, 1, 3,1,1, 1,0,0);
    add(0,0,3,0,10000,11, 3,1,1, 1,0,0);
    add(0,0,3,0,10000, 1, 4,0,1, 2,0,0);
    // Start while running is ignored
    add(1,0,3,0,10000, 1, 4,0,1, 2,0,0);

    bus.machine_start = 1'b0;
    bus.machine_stop  = 1'b0;
    bus.ton_data      = 16'd0;
    bus.toff_data     = 16'd0;
    bus.gap_volt      = 16'd20000;

    repeat (3) @(posedge clk);
    #1;
    z = '{start:0, stop:0, ton:0, toff:0, gap:0, cyc:0, st:0, mos:0, run:0, pc:0, sc:0, oc:0};
    chk_outputs("reset", z);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < vt.size(); i++) begin
      bus.machine_start = vt[i].start;
      bus.machine_stop  = vt[i].stop;
      bus.ton_data      = vt[i].ton;
      bus.toff_data     = vt[i].toff;
      bus.gap_volt      = vt[i].gap;
      step();
      bus.machine_start = 1'b0;
      bus.machine_stop  = 1'b0;
      for (int c = 1; c < vt[i].cyc; c++) step();
      chk_outputs($sformatf("v%0d", i), vt[i]);
    end

    // Asynchronous reset while the gap is energised
    n = 0;
    while (bus.state_o != 3'd3 && n < 50) begin
      step();
      n++;
    end
    chk("reach discharge before reset", int'(n < 50), 1);
    chk("mosfet before reset", int'(bus.mosfet_on), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset mosfet", int'(bus.mosfet_on), 0);
    chk("async reset state", int'(bus.state_o), 0);
    chk("async reset pulse", int'(bus.pulse_cnt), 0);
    chk("async reset running", int'(bus.running), 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // ton=2 gives a gate pulse of exactly 8 clk in DISCHARGE
    bus.ton_data  = 16'd2;
    bus.toff_data = 16'd1;
    bus.gap_volt  = 16'd10000;
    bus.machine_start = 1'b1;
    step();
    bus.machine_start = 1'b0;
    n = 0;
    while (bus.state_o != 3'd3 && n < 50) begin
      step();
      n++;
    end
    chk("reach discharge ton=2", int'(n < 50), 1);
    w = 0;
    while (bus.mosfet_on && bus.state_o == 3'd3 && w < 100) begin
      w++;
      step();
    end
    chk("ton=2 width", w, 8);
    chk("after ton=2 state", int'(bus.state_o), 4);
    chk("after ton=2 mosfet", int'(bus.mosfet_on), 0);
    chk("after ton=2 pulse", int'(bus.pulse_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
